q15_sat_alu: RTL and testbench

Pipelined, parametrised saturating fixed-point add/subtract/accumulate unit with valid/ready handshakes on both sides. It succeeds the combinational 64-bit saturating adder and adds selectable width, an internal accumulator, registered latency, per-result overflow reporting and a sticky overflow status. It sits between the operand-fetch stage and the result writeback of the fixed-point datapath.

---
 rtl/q15_sat_alu_if.sv | 28 ++
 rtl/q15_sat_alu.sv | 112 +++++++++++
 tb/tb_q15_sat_alu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/q15_sat_alu_if.sv
// Operand/result handshake bundle for q15_sat_alu, plus accumulator and
// sticky-overflow status lines.
interface q15_sat_alu_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic [WIDTH-1:0] acc_q;
    logic             sat_sticky;
    logic             sticky_clr;

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready, sticky_clr,
        output in_ready, out_valid, out_data, out_ovf, acc_q, sat_sticky
    );

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready, sticky_clr,
        input  in_ready, out_valid, out_data, out_ovf, acc_q, sat_sticky
    );
endinterface

// File: rtl/q15_sat_alu.sv
// Two-stage saturating add/sub/accumulate unit with valid/ready on both sides.
// S1 holds the accepted beat; S2 holds the result and owns the accumulator.
module q15_sat_alu #(
    parameter int WIDTH = 64,
    parameter int FRAC  = 15
) (
    input  logic          clk,
    input  logic          rst_n,
    q15_sat_alu_if.slave  bus_io
);
    typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ACC = 2'd2, OP_LOAD = 2'd3} op_e;

    localparam logic [WIDTH-1:0] MAX_V = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_V = {1'b1, {(WIDTH-1){1'b0}}};

    generate
        if (WIDTH < 4 || FRAC < 0 || FRAC >= WIDTH) begin : g_bad_cfg
            $error("q15_sat_alu: invalid WIDTH/FRAC combination");
        end
    endgenerate

    logic             s1_valid_q;
    op_e              s1_op_q;
    logic [WIDTH-1:0] s1_a_q;
    logic [WIDTH-1:0] s1_b_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] out_data_q;
    logic             out_ovf_q;
    logic [WIDTH-1:0] acc_val_q;
    logic             sticky_q;

    logic             adv2;
    logic             in_ready;
    logic             xfer12;
    logic [WIDTH-1:0] lhs;
    logic [WIDTH-1:0] rhs;
    logic [WIDTH:0]   sum_x;
    logic [WIDTH-1:0] res_d;
    logic             ovf_d;

    assign adv2     = !out_valid_q || bus_io.out_ready;
    assign in_ready = !s1_valid_q || adv2;
    assign xfer12   = s1_valid_q && adv2;

    // ACC uses the accumulator as the first operand; its sign picks the rail.
    always_comb begin
        lhs   = (s1_op_q == OP_ACC) ? acc_val_q : s1_a_q;
        rhs   = (s1_op_q == OP_ACC) ? s1_a_q : s1_b_q;
        sum_x = (s1_op_q == OP_SUB) ? ({lhs[WIDTH-1], lhs} - {rhs[WIDTH-1], rhs})
                                    : ({lhs[WIDTH-1], lhs} + {rhs[WIDTH-1], rhs});
        ovf_d = (s1_op_q != OP_LOAD) && (sum_x[WIDTH] != sum_x[WIDTH-1]);
        if (s1_op_q == OP_LOAD) begin
            res_d = s1_a_q;
        end else if (ovf_d) begin
            res_d = lhs[WIDTH-1] ? MIN_V : MAX_V;
        end else begin
            res_d = sum_x[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_op_q    <= OP_ADD;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
        end else if (bus_io.in_valid && in_ready) begin
            s1_valid_q <= 1'b1;
            s1_op_q    <= op_e'(bus_io.in_op);
            s1_a_q     <= bus_io.in_a;
            s1_b_q     <= bus_io.in_b;
        end else if (xfer12) begin
            s1_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            acc_val_q   <= '0;
        end else if (xfer12) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_ovf_q   <= ovf_d;
            if (s1_op_q == OP_ACC || s1_op_q == OP_LOAD) begin
                acc_val_q <= res_d;
            end
        end else if (bus_io.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // A saturating transfer takes priority over a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
        end else if (xfer12 && ovf_d) begin
            sticky_q <= 1'b1;
        end else if (bus_io.sticky_clr) begin
            sticky_q <= 1'b0;
        end
    end

    assign bus_io.in_ready   = in_ready;
    assign bus_io.out_valid  = out_valid_q;
    assign bus_io.out_data   = out_data_q;
    assign bus_io.out_ovf    = out_ovf_q;
    assign bus_io.acc_q      = acc_val_q;
    assign bus_io.sat_sticky = sticky_q;
endmodule

// File: tb/tb_q15_sat_alu.sv
// Scoreboard bench for q15_sat_alu at WIDTH=16: a negedge monitor models each
// accepted beat and compares each delivered result in order.
module tb_q15_sat_alu;
    localparam int W = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    q15_sat_alu_if #(.WIDTH(W)) bus ();
    q15_sat_alu #(.WIDTH(W), .FRAC(15)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (bus)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [16:0] sb_q[$];
    logic [15:0] model_acc = '0;
    logic [16:0] exp_e;
    logic [16:0] got_e;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    endtask

    function automatic logic [16:0] model(input logic [1:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [15:0] acc);
        int x, y, r;
        logic o;
        x = (op == 2'd2) ? int'($signed(acc)) : int'($signed(a));
        y = (op == 2'd2) ? int'($signed(a))   : int'($signed(b));
        case (op)
            2'd1:    r = x - y;
            2'd3:    r = int'($signed(a));
            default: r = x + y;
        endcase
        o = 1'b0;
        if (r > 32767) begin
            r = 32767;  o = 1'b1;
        end else if (r < -32768) begin
            r = -32768; o = 1'b1;
        end
        return {o, r[15:0]};
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            model_acc = '0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_out", 32'd1, 32'd0);
                end else begin
                    got_e = sb_q.pop_front();
                    $display("OUT data=0x%04h ovf=%0b", bus.out_data, bus.out_ovf);
                    chk("out_data", bus.out_data, got_e[15:0]);
                    chk("out_ovf", bus.out_ovf, got_e[16]);
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                exp_e = model(bus.in_op, bus.in_a, bus.in_b, model_acc);
                sb_q.push_back(exp_e);
                if (bus.in_op == 2'd2 || bus.in_op == 2'd3) model_acc = exp_e[15:0];
                $display("IN  op=%0d a=0x%04h b=0x%04h", bus.in_op, bus.in_a, bus.in_b);
            end
        end
    end

    task automatic send(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        output int waits);
        logic done;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        waits = 0;
        done  = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            done = bus.in_ready;
            @(posedge clk); #1;
            if (!done) waits++;
        end
        if (!done) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb_q.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        chk("drain_empty", sb_q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    logic [15:0] bp_op_a [4];
    logic [15:0] bp_op_b [4];
    logic [1:0]  bp_op   [4];

    initial begin
        int w;
        int idx;
        logic r;
        logic [15:0] held;
        logic held_ovf;

        bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_a = '0; bus.in_b = '0;
        bus.out_ready = 1'b1; bus.sticky_clr = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_ovf", bus.out_ovf, 0);
        chk("rst_acc", bus.acc_q, 0);
        chk("rst_sticky", bus.sat_sticky, 0);
        @(posedge clk); #1;

        // ADD with latency check
        send(2'd0, 16'h7000, 16'h2000, w);
        bus.in_valid = 1'b0;
        @(negedge clk); chk("lat1_cyc1_valid", bus.out_valid, 0);
        @(negedge clk); chk("lat1_cyc2_valid", bus.out_valid, 1);
        chk("add_ovf_sticky", bus.sat_sticky, 1);
        @(posedge clk); #1;
        send(2'd0, 16'h1234, 16'h0001, w);
        bus.in_valid = 1'b0;
        @(negedge clk); chk("lat2_cyc1_valid", bus.out_valid, 0);
        @(negedge clk); chk("lat2_cyc2_valid", bus.out_valid, 1);
        @(posedge clk); #1;

        // SUB streamed
        send(2'd1, 16'h8000, 16'h0001, w);
        send(2'd1, 16'h0000, 16'h8000, w);
        send(2'd1, 16'h0005, 16'h0007, w);
        bus.in_valid = 1'b0;
        drain();

        // Accumulate chain
        send(2'd3, 16'h4000, 16'h0000, w); chk("chain_ready0", w, 0);
        send(2'd2, 16'h3000, 16'h0000, w); chk("chain_ready1", w, 0);
        send(2'd2, 16'h2000, 16'h0000, w); chk("chain_ready2", w, 0);
        send(2'd2, 16'hC000, 16'h0000, w); chk("chain_ready3", w, 0);
        bus.in_valid = 1'b0;
        drain();
        chk("chain_acc", bus.acc_q, 16'h3FFF);

        // Backpressure
        bp_op[0] = 2'd3; bp_op_a[0] = 16'h0100; bp_op_b[0] = 16'h0000;
        bp_op[1] = 2'd2; bp_op_a[1] = 16'h0010; bp_op_b[1] = 16'h0000;
        bp_op[2] = 2'd0; bp_op_a[2] = 16'h7FFF; bp_op_b[2] = 16'h0001;
        bp_op[3] = 2'd2; bp_op_a[3] = 16'h0005; bp_op_b[3] = 16'h0000;
        bus.out_ready = 1'b0;
        idx = 0;
        held = '0; held_ovf = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_op = bp_op[idx]; bus.in_a = bp_op_a[idx]; bus.in_b = bp_op_b[idx];
            @(negedge clk);
            r = bus.in_ready;
            if (c >= 2) begin
                chk("bp_in_ready_low", r, 0);
                chk("bp_out_valid", bus.out_valid, 1);
                chk("bp_acc_hold", bus.acc_q, 16'h0100);
                if (c == 2) begin
                    held = bus.out_data; held_ovf = bus.out_ovf;
                end else begin
                    chk("bp_data_stable", bus.out_data, held);
                    chk("bp_ovf_stable", bus.out_ovf, held_ovf);
                end
            end
            @(posedge clk); #1;
            if (r) idx++;
        end
        chk("bp_accepted", idx, 2);
        bus.out_ready = 1'b1;
        while (idx < 4) begin
            send(bp_op[idx], bp_op_a[idx], bp_op_b[idx], w);
            idx++;
        end
        bus.in_valid = 1'b0;
        drain();
        chk("bp_acc_final", bus.acc_q, 16'h0115);

        // Sticky clear race
        bus.sticky_clr = 1'b1;
        send(2'd0, 16'h7000, 16'h2000, w);
        bus.in_valid = 1'b0;
        @(negedge clk); chk("sticky_pre_clear", bus.sat_sticky, 0);
        @(negedge clk); chk("sticky_set_wins", bus.sat_sticky, 1);
        @(negedge clk); chk("sticky_cleared", bus.sat_sticky, 0);
        @(posedge clk); #1;
        bus.sticky_clr = 1'b0;
        drain();

        // Reset mid-stream
        send(2'd3, 16'h1234, 16'h0000, w);
        bus.in_valid = 1'b0;
        drain();
        chk("pre_rst_acc", bus.acc_q, 16'h1234);
        bus.out_ready = 1'b0;
        send(2'd0, 16'h0001, 16'h0001, w);
        send(2'd0, 16'h0002, 16'h0002, w);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("mrst_out_valid", bus.out_valid, 0);
        chk("mrst_out_data", bus.out_data, 0);
        chk("mrst_out_ovf", bus.out_ovf, 0);
        chk("mrst_acc", bus.acc_q, 0);
        chk("mrst_sticky", bus.sat_sticky, 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk); chk("no_stale_out", bus.out_valid, 0);
        end
        @(posedge clk); #1;
        send(2'd2, 16'h0001, 16'h0000, w);
        bus.in_valid = 1'b0;
        drain();
        chk("post_rst_acc", bus.acc_q, 16'h0001);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
